cordivall_param: RTL and testbench
==================================

# cordivall_param

Parametrised stochastic-computing divider with bitstream regeneration. Each input bitstream (dividend, divisor) drives an up/down counter. The counter value is compared against a shared random number to produce a regenerated, mutually correlated stream. The regenerated streams feed a CORDIV core whose history register depth, counter width and saturation mode are set at elaboration. The block adds a synchronous clear, a hold enable and a warm-up valid flag, and sits in the SC datapath wherever a ratio of two uncorrelated streams is needed.

## Interface
Parameters:
- CNT_W, 8, counter and random-number width (≥2)
- DEPTH, 2, CORDIV history register depth (≥2)
- SATURATE, 1, 1 = counters clamp at 0 / 2^CNT_W−1; 0 = counters wrap
- WARMUP, 16, number of enabled cycles before out_valid asserts (≥1)

Ports:
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- en  in  1  advance enable; 0 freezes all state
- clr  in  1  synchronous clear to reset values; has priority over en
- randnum  in  CNT_W  shared random threshold, fresh each cycle
- sel  in  SEL_W=$clog2(DEPTH)  random history index
- dividend  in  1  dividend bitstream
- divisor  in  1  divisor bitstream
- quotient  out  1  registered quotient bitstream
- out_valid  out  1  high once WARMUP enabled cycles have elapsed since reset or clr

## Operation
- Counters dvd_cnt and dvs_cnt (CNT_W bits):
  - Reset/clr value 2^(CNT_W−1), i.e. 0x80 for CNT_W=8.
  - When en=1: +1 if the input bit is 1, −1 if it is 0.
  - SATURATE=1: no increment at all-ones, no decrement at 0.
  - SATURATE=0: modulo 2^CNT_W wrap.
- Regeneration is combinational: dvd_rg = (dvd_cnt ≥ randnum), dvs_rg = (dvs_cnt ≥ randnum), unsigned compare. Both streams use the same randnum, which is what makes them correlated.
- CORDIV core:
  - Holds hist[DEPTH−1:0], reset/clr 0.
  - q_next = dvs_rg ? dvd_rg : hist[idx], where idx = sel when sel < DEPTH and idx = DEPTH−1 otherwise.
  - On en=1 with dvs_rg=1, hist shifts: hist[0] ← dvd_rg, hist[i] ← hist[i−1].
  - On en=1 with dvs_rg=0, hist is unchanged.
  - On en=1, quotient ← q_next.
- Warm-up counter:
  - Width $clog2(WARMUP+1); counts enabled cycles and saturates at WARMUP.
  - out_valid = (count == WARMUP).
- clr=1 returns counters, hist, quotient, warm-up count and out_valid to their reset values on that edge, regardless of en.

## Timing
- Reset values: quotient=0, out_valid=0, both counters 2^(CNT_W−1), hist all 0.
- Latency: an input bit sampled at edge k updates the counter at edge k. It affects dvd_rg/dvs_rg in cycle k→k+1 and appears in quotient after edge k+1. Input-to-quotient latency is 2 edges.
- randnum and sel are consumed combinationally in the same cycle as the q_next evaluation, with no extra pipelining.
- en=0: every register holds, and quotient and out_valid stay stable.
- Assertion of rst_n mid-operation takes effect immediately (async). Release is synchronous to clk by the surrounding reset synchroniser.
- clr and en both high: clr wins; the cycle does not count toward warm-up.
- Saturation boundaries (SATURATE=1):
  - Counter at 2^CNT_W−1 with input 1 stays.
  - Counter at 0 with input 0 stays.
  - randnum=0 always yields regen 1; a counter at 0 with randnum=0 also yields 1.
- out_valid rises on the edge where the warm-up count reaches WARMUP and stays high until reset or clr.

## Structure
- Package cordiv_pkg:
  - Default constants: CORDIV_CNT_W=8, CORDIV_DEPTH=2.
  - Function cnt_mid(width) returning 2^(width−1).
  - Function for SEL_W.
- Sub-module cordiv_core (params DEPTH): ports clk, rst_n, en, clr, sel, dividend, divisor, quotient. It contains hist and the quotient register.
- Counters, comparators and warm-up logic live in the top.

## Test plan
- Reset, CNT_W=8 / DEPTH=4: hold rst_n=0, then release with en=0 → quotient=0, out_valid=0, counters 0x80, state held for 10 cycles.
- SATURATE=1, dividend=divisor=1, randnum=0x80, en=1 → quotient=1 from the 2nd edge onward. After 127 edges dvd_cnt=0xFF, and it stays 0xFF for the following 20 cycles.
- SATURATE=0, dividend=1 for 128 edges → dvd_cnt wraps 0xFF→0x00. With randnum=0x01, dvd_rg drops to 0 on the cycle after the wrap.
- History select, DEPTH=4: drive regenerated pattern dvd_rg=1,0,1,1 with dvs_rg=1, then force dvs_rg=0 (divisor=0, randnum=0xFF). Sel=0..3 → quotient=1,1,0,1 with 2-edge latency; sel=5 behaves as sel=3.
- Control: en=0 for 5 cycles → no change anywhere. clr pulse after 30 cycles → all reset values next edge. out_valid re-asserts exactly WARMUP=16 enabled cycles later.
- Statistical: CNT_W=8, DEPTH=4; 8-bit LFSRs for randnum/sel, dividend p=0.25, divisor p=0.5, 4096 cycles after out_valid → mean(quotient)=0.50±0.03.

Source files
------------

// File: rtl/cordiv_pkg.sv
// cordiv_pkg: shared defaults and sizing helpers for the CORDIV divider
package cordiv_pkg;
  localparam int CORDIV_CNT_W = 8;
  localparam int CORDIV_DEPTH = 2;
  function automatic int cnt_mid(input int width);
    return 1 << (width - 1);
  endfunction
  function automatic int sel_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/cordiv_core.sv
// cordiv_core: CORDIV history register and registered quotient bitstream
module cordiv_core import cordiv_pkg::*; #(
  parameter int DEPTH = CORDIV_DEPTH,
  localparam int SEL_W = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [SEL_W-1:0] sel,
  input  logic             dividend,
  input  logic             divisor,
  output logic             quotient
);
  logic [DEPTH-1:0] hist_q, hist_d;
  logic quotient_q, quotient_d, hsel;
  always_comb begin
    hsel = hist_q[DEPTH-1];
    for (int i = 0; i < DEPTH - 1; i++) hsel = (sel == SEL_W'(i)) ? hist_q[i] : hsel;
    quotient_d = divisor ? dividend : hsel;
    hist_d = divisor ? {hist_q[DEPTH-2:0], dividend} : hist_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      quotient_q <= 1'b0;
    end else if (clr) begin
      hist_q <= '0;
      quotient_q <= 1'b0;
    end else if (en) begin
      hist_q <= hist_d;
      quotient_q <= quotient_d;
    end
  end
  assign quotient = quotient_q;
endmodule

// File: rtl/cordivall_param.sv
// cordivall_param: SC divider with counter-based bitstream regeneration feeding a CORDIV core
module cordivall_param import cordiv_pkg::*; #(
  parameter int CNT_W = CORDIV_CNT_W,
  parameter int DEPTH = CORDIV_DEPTH,
  parameter int SATURATE = 1,
  parameter int WARMUP = 16,
  localparam int SEL_W = sel_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] randnum,
  input  logic [SEL_W-1:0] sel,
  input  logic             dividend,
  input  logic             divisor,
  output logic             quotient,
  output logic             out_valid
);
  localparam int WU_W = $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0] MID = CNT_W'(cnt_mid(CNT_W));
  localparam logic [WU_W-1:0] WU_MAX = WU_W'(WARMUP);
  logic [CNT_W-1:0] dvd_cnt_q, dvd_cnt_d, dvs_cnt_q, dvs_cnt_d;
  logic [WU_W-1:0] wu_q, wu_d;
  logic dvd_rg, dvs_rg;
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic up);
    return (SATURATE != 0 && (up ? &c : ~|c)) ? c : (up ? c + 1'b1 : c - 1'b1);
  endfunction
  // a shared threshold is what correlates the two regenerated streams
  always_comb begin
    dvd_cnt_d = cnt_step(dvd_cnt_q, dividend);
    dvs_cnt_d = cnt_step(dvs_cnt_q, divisor);
    wu_d = (wu_q == WU_MAX) ? wu_q : wu_q + 1'b1;
    dvd_rg = dvd_cnt_q >= randnum;
    dvs_rg = dvs_cnt_q >= randnum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_cnt_q <= MID;
      dvs_cnt_q <= MID;
      wu_q <= '0;
    end else if (clr) begin
      dvd_cnt_q <= MID;
      dvs_cnt_q <= MID;
      wu_q <= '0;
    end else if (en) begin
      dvd_cnt_q <= dvd_cnt_d;
      dvs_cnt_q <= dvs_cnt_d;
      wu_q <= wu_d;
    end
  end
  assign out_valid = wu_q == WU_MAX;
  cordiv_core #(.DEPTH(DEPTH)) u_core (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .sel(sel),
    .dividend(dvd_rg), .divisor(dvs_rg), .quotient(quotient)
  );
endmodule

// File: tb/tb_cordivall_param.sv
// tb_cordivall_param: scoreboard bench comparing two divider configurations against a behavioural model
module tb_cordivall_param;
  logic clk = 0, rst_n = 0, en = 0, clr = 0, dividend = 0, divisor = 0;
  logic [7:0] randnum = 0;
  logic [1:0] sel = 0;
  logic q0, v0, q1, v1;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  cordivall_param #(.CNT_W(8), .DEPTH(4), .SATURATE(1), .WARMUP(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .randnum(randnum), .sel(sel),
    .dividend(dividend), .divisor(divisor), .quotient(q0), .out_valid(v0));
  cordivall_param #(.CNT_W(8), .DEPTH(3), .SATURATE(0), .WARMUP(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .randnum(randnum), .sel(sel),
    .dividend(dividend), .divisor(divisor), .quotient(q1), .out_valid(v1));
  typedef struct {bit q; bit v; int c;} exp_t;
  exp_t sb0[$], sb1[$];
  int m_dvd[2], m_dvs[2], m_wu[2];
  bit m_hist[2][4];
  bit m_q[2];
  localparam int DEP[2] = '{4, 3};
  localparam bit SAT[2] = '{1'b1, 1'b0};
  function automatic void chk(string n, int d, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", n, d, $time, act, exp);
    end
  endfunction
  function automatic int upd(int c, bit up, bit sat);
    if (sat) return up ? ((c == 255) ? c : c + 1) : ((c == 0) ? 0 : c - 1);
    return (c + (up ? 1 : 255)) % 256;
  endfunction
  function automatic void model_reset(int d);
    m_dvd[d] = 128; m_dvs[d] = 128; m_wu[d] = 0; m_q[d] = 0;
    for (int i = 0; i < 4; i++) m_hist[d][i] = 0;
  endfunction
  function automatic void model_step(int d);
    bit a, b;
    int idx;
    exp_t e;
    if (!rst_n || clr) model_reset(d);
    else if (en) begin
      a = m_dvd[d] >= int'(randnum);
      b = m_dvs[d] >= int'(randnum);
      idx = (int'(sel) < DEP[d]) ? int'(sel) : DEP[d] - 1;
      m_q[d] = b ? a : m_hist[d][idx];
      if (b) begin
        for (int i = DEP[d] - 1; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
        m_hist[d][0] = a;
      end
      m_dvd[d] = upd(m_dvd[d], dividend, SAT[d]);
      m_dvs[d] = upd(m_dvs[d], divisor, SAT[d]);
      m_wu[d] = (m_wu[d] < 16) ? m_wu[d] + 1 : 16;
    end
    e.q = m_q[d]; e.v = m_wu[d] == 16; e.c = m_dvd[d];
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
  endfunction
  task automatic drive(bit r, bit e, bit c, bit dv, bit ds, logic [7:0] rn, logic [1:0] s);
    bit fell;
    @(negedge clk);
    fell = rst_n && !r;
    rst_n = r; en = e; clr = c; dividend = dv; divisor = ds; randnum = rn; sel = s;
    model_step(0);
    model_step(1);
    if (fell) begin
      #1;
      chk("async_rst_q", 0, int'(q0), 0);
      chk("async_rst_v", 1, int'(v1), 0);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      chk("quotient", 0, int'(q0), int'(e.q));
      chk("out_valid", 0, int'(v0), int'(e.v));
      chk("dvd_cnt", 0, int'(dut0.dvd_cnt_q), e.c);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk("quotient", 1, int'(q1), int'(e.q));
      chk("out_valid", 1, int'(v1), int'(e.v));
      chk("dvd_cnt", 1, int'(dut1.dvd_cnt_q), e.c);
    end
  end
  initial begin
    int bias;
    model_reset(0);
    model_reset(1);
    repeat (3) drive(0, 0, 0, 0, 0, 8'h00, 2'd0);
    repeat (10) drive(1, 0, 0, 1, 1, 8'(($urandom)), 2'($urandom));
    repeat (150) drive(1, 1, 0, 1, 1, 8'h80, 2'd0);
    repeat (20) drive(1, 1, 0, 1, 1, 8'h01, 2'd1);
    drive(1, 1, 1, 1, 1, 8'h80, 2'd0);
    foreach (DEP[k]) begin
      drive(1, 1, 0, 1, 1, 8'h80, 2'd0);
      drive(1, 1, 0, 0, 1, 8'h82, 2'd0);
      drive(1, 1, 0, 1, 1, 8'h80, 2'd0);
      drive(1, 1, 0, 1, 1, 8'h80, 2'd0);
      for (int s = 0; s < 4; s++) begin
        drive(1, 1, 0, 0, 0, 8'hFF, 2'(s));
        drive(1, 1, 0, 0, 0, 8'hFF, 2'(s));
      end
    end
    repeat (5) drive(1, 0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
    repeat (30) drive(1, 1, 0, 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
    drive(1, 1, 1, 1, 1, 8'h00, 2'd0);
    repeat (20) drive(1, 1, 0, 1'($urandom), 1'($urandom), 8'($urandom), 2'($urandom));
    for (int blk = 0; blk < 15; blk++) begin
      bias = $urandom_range(0, 100);
      repeat (200)
        drive($urandom_range(0, 599) != 0, ($urandom % 10) != 0, ($urandom % 100) == 0,
              $urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
              8'($urandom), 2'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("sb0_drained", 0, sb0.size(), 0);
    chk("sb1_drained", 1, sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
